// File: rtl/conv_sched.sv
// conv_sched: tile/layer job scheduler for a convolution engine.
//
// One run walks every (layer, tile_row, tile_col) tile. tile_col is the
// innermost loop and layer_id the outermost. Each tile is processed one
// input-channel group at a time: one conv_start job per group, and each job
// waits for conv_done from the engine. When the last group of a tile
// finishes, the tile is written back with a single wb_en strobe. The
// unshuffle stage runs once at the start of a run.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous, active-high reset
//   enable       run request (level)
//   valid_un     unshuffle-complete pulse (only used in UNSH)
//   conv_done    conv engine job-complete pulse (only used in WAIT)
//   unshuffle_en enables the unshuffle stage
//   conv_start   one-cycle job launch to the conv engine
//   acc_clear    accumulator clear, with conv_start for group 0
//   wb_en        one-cycle tile writeback strobe
//   layer_id     current layer
//   tile_row     current tile row
//   tile_col     current tile column
//   grp_id       current input-channel group
//   busy         high in every state except IDLE and DONE
//   valid        run complete (DONE)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for enable
// UNSH  | unshuffle running, waiting for valid_un
// ISSUE | one-cycle conv_start for the current (tile, group)
// WAIT  | waiting for conv_done of the job just issued
// WB    | one-cycle writeback of the finished tile
// DONE  | run complete, counters cleared, waiting for enable to drop

module conv_sched #(
  parameter  int N_LAYER = 3,
  parameter  int N_ROW   = 6,
  parameter  int N_COL   = 6,
  parameter  int N_GRP   = 4,
  localparam int LW = (N_LAYER > 1) ? $clog2(N_LAYER) : 1,
  localparam int RW = (N_ROW   > 1) ? $clog2(N_ROW)   : 1,
  localparam int CW = (N_COL   > 1) ? $clog2(N_COL)   : 1,
  localparam int GW = (N_GRP   > 1) ? $clog2(N_GRP)   : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          valid_un,
  input  logic          conv_done,
  output logic          unshuffle_en,
  output logic          conv_start,
  output logic          acc_clear,
  output logic          wb_en,
  output logic [LW-1:0] layer_id,
  output logic [RW-1:0] tile_row,
  output logic [CW-1:0] tile_col,
  output logic [GW-1:0] grp_id,
  output logic          busy,
  output logic          valid
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_UNSH  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [LW-1:0] LAYER_MAX = LW'(N_LAYER - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(N_ROW - 1);
  localparam logic [CW-1:0] COL_MAX   = CW'(N_COL - 1);
  localparam logic [GW-1:0] GRP_MAX   = GW'(N_GRP - 1);

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [LW-1:0] layer_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [GW-1:0] grp_q;

  logic last_grp;
  logic last_col;
  logic last_row;
  logic last_layer;
  logic last_tile;

  assign last_grp   = (grp_q   == GRP_MAX);
  assign last_col   = (col_q   == COL_MAX);
  assign last_row   = (row_q   == ROW_MAX);
  assign last_layer = (layer_q == LAYER_MAX);
  assign last_tile  = last_col && last_row && last_layer;

  // Next-state logic. Inputs are only looked at in the one state that
  // owns them, so stray pulses elsewhere are dropped by construction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_UNSH;
      S_UNSH:  if (valid_un) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (conv_done) state_d = last_grp ? S_WB : S_ISSUE;
      end
      S_WB:    state_d = last_tile ? S_DONE : S_ISSUE;
      S_DONE:  if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Loop counters. grp_id steps inside WAIT; the tile counters only move
  // on the way out of WB so that wb_en still names the finished tile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      grp_q   <= '0;
    end else begin
      case (state_q)
        S_UNSH, S_ISSUE: begin
          // counters hold
        end
        S_WAIT: begin
          if (conv_done && !last_grp) grp_q <= grp_q + GW'(1);
        end
        S_WB: begin
          grp_q <= '0;
          if (last_col) begin
            col_q <= '0;
            if (last_row) begin
              row_q   <= '0;
              layer_q <= last_layer ? '0 : layer_q + LW'(1);
            end else begin
              row_q <= row_q + RW'(1);
            end
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        default: begin
          // IDLE, DONE and illegal encodings: start every run from tile 0
          layer_q <= '0;
          row_q   <= '0;
          col_q   <= '0;
          grp_q   <= '0;
        end
      endcase
    end
  end

  // Moore outputs
  assign unshuffle_en = (state_q == S_UNSH);
  assign conv_start   = (state_q == S_ISSUE);
  assign acc_clear    = (state_q == S_ISSUE) && (grp_q == '0);
  assign wb_en        = (state_q == S_WB);
  assign valid        = (state_q == S_DONE);
  assign busy         = (state_q == S_UNSH) || (state_q == S_ISSUE) ||
                        (state_q == S_WAIT) || (state_q == S_WB);

  assign layer_id = layer_q;
  assign tile_row = row_q;
  assign tile_col = col_q;
  assign grp_id   = grp_q;

endmodule
